// File: rtl/i2s_rx.sv
// I2S receiver: oversamples bck/lrck/adata on clk and delivers left/right sample pairs with a one-cycle o_valid.
// o_valid appears SYNC_STAGES+2 clk after i_bck is first seen high for the right word's last captured bit; no backpressure.
module i2s_rx #(
  parameter int DATA_WIDTH  = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_bck,
  input  logic                  i_lrck,
  input  logic                  i_adata,
  output logic [DATA_WIDTH-1:0] o_left,
  output logic [DATA_WIDTH-1:0] o_right,
  output logic                  o_valid,
  output logic                  o_frame_err,
  output logic                  o_err_sticky
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_bck_sync;
  logic [SYNC_STAGES-1:0] r_lrck_sync;
  logic [SYNC_STAGES-1:0] r_adata_sync;
  logic                   r_bck_d;
  logic                   r_lrck_prev;
  logic                   r_primed;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CW-1:0]          r_bit_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  logic                   r_chan;
  logic                   w_chan_nxt;
  logic [DATA_WIDTH-1:0]  r_sr;
  logic [DATA_WIDTH-1:0]  r_left_hold;
  logic                   r_left_ok;
  logic                   r_pair_vld;
  logic                   r_err_pend;

  logic [DATA_WIDTH-1:0]  r_left;
  logic [DATA_WIDTH-1:0]  r_right;
  logic                   r_valid;
  logic                   r_frame_err;
  logic                   r_err_sticky;

  logic                   w_bck_re;
  logic                   w_lrck;
  logic                   w_dat;
  logic                   w_lr_edge;
  logic                   w_shift;
  logic                   w_left_done;
  logic                   w_right_done;
  logic                   w_short;

  // lrck and data are taken from the same stage as the bck edge so all three stay aligned.
  assign w_bck_re  = r_bck_sync[SYNC_STAGES-1] & ~r_bck_d;
  assign w_lrck    = r_lrck_sync[SYNC_STAGES-1];
  assign w_dat     = r_adata_sync[SYNC_STAGES-1];
  // The first bck edge after reset only primes lrck_prev, so a reset released mid-slot never fakes an edge.
  assign w_lr_edge = w_bck_re & r_primed & (w_lrck != r_lrck_prev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bck_sync   <= '0;
      r_lrck_sync  <= '0;
      r_adata_sync <= '0;
      r_bck_d      <= 1'b0;
      r_lrck_prev  <= 1'b0;
      r_primed     <= 1'b0;
    end else begin
      r_bck_sync   <= {r_bck_sync[SYNC_STAGES-2:0], i_bck};
      r_lrck_sync  <= {r_lrck_sync[SYNC_STAGES-2:0], i_lrck};
      r_adata_sync <= {r_adata_sync[SYNC_STAGES-2:0], i_adata};
      r_bck_d      <= r_bck_sync[SYNC_STAGES-1];
      if (w_bck_re) begin
        r_lrck_prev <= w_lrck;
        r_primed    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_chan    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_cnt_nxt;
      r_chan    <= w_chan_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_bit_cnt;
    w_chan_nxt   = r_chan;
    w_shift      = 1'b0;
    w_left_done  = 1'b0;
    w_right_done = 1'b0;
    w_short      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_lr_edge) begin
          w_chan_nxt  = w_lrck;
          w_cnt_nxt   = '0;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (r_bit_cnt == CNT_MAX) begin
          w_state_nxt  = WAIT;
          w_left_done  = ~r_chan;
          w_right_done = r_chan;
        end else if (w_lr_edge) begin
          w_short    = 1'b1;
          w_chan_nxt = w_lrck;
          w_cnt_nxt  = '0;
        end else if (w_bck_re) begin
          w_shift   = 1'b1;
          w_cnt_nxt = r_bit_cnt + CW'(1);
        end
      end
      WAIT: begin
        if (w_lr_edge) begin
          w_chan_nxt  = w_lrck;
          w_cnt_nxt   = '0;
          w_state_nxt = SHIFT;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr        <= '0;
      r_left_hold <= '0;
      r_left_ok   <= 1'b0;
      r_pair_vld  <= 1'b0;
      r_err_pend  <= 1'b0;
    end else begin
      if (w_shift) begin
        r_sr <= {r_sr[DATA_WIDTH-2:0], w_dat};
      end
      if (w_left_done) begin
        r_left_hold <= r_sr;
      end
      if (w_short) begin
        r_left_ok <= 1'b0;
      end else if (w_left_done) begin
        r_left_ok <= 1'b1;
      end else if (w_right_done) begin
        r_left_ok <= 1'b0;
      end
      r_pair_vld <= w_right_done & r_left_ok;
      r_err_pend <= w_short;
    end
  end

  // sr and the left hold are frozen until the next bck edge, so the output stage can read them a cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_left       <= '0;
      r_right      <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_valid     <= r_pair_vld;
      r_frame_err <= r_err_pend;
      if (r_pair_vld) begin
        r_left  <= r_left_hold;
        r_right <= r_sr;
      end
      if (r_err_pend) begin
        r_err_sticky <= 1'b1;
      end
    end
  end

  assign o_left       = r_left;
  assign o_right      = r_right;
  assign o_valid      = r_valid;
  assign o_frame_err  = r_frame_err;
  assign o_err_sticky = r_err_sticky;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: an inline I2S source drives 32-bit slots and a negedge monitor tallies pulses.
module tb_i2s_rx;

  localparam int DW = 24;

  logic          clk;
  logic          rst_n;
  logic          i_bck;
  logic          i_lrck;
  logic          i_adata;
  logic [DW-1:0] o_left;
  logic [DW-1:0] o_right;
  logic          o_valid;
  logic          o_frame_err;
  logic          o_err_sticky;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rise_cyc = 0;
  int n_valid  = 0;
  int n_err    = 0;
  int n_both   = 0;
  int vld_cyc  = 0;
  logic [DW-1:0] last_l = '0;
  logic [DW-1:0] last_r = '0;

  i2s_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_bck        (i_bck),
    .i_lrck       (i_lrck),
    .i_adata      (i_adata),
    .o_left       (o_left),
    .o_right      (o_right),
    .o_valid      (o_valid),
    .o_frame_err  (o_frame_err),
    .o_err_sticky (o_err_sticky)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      n_valid = n_valid + 1;
      last_l  = o_left;
      last_r  = o_right;
      vld_cyc = cyc;
    end
    if (o_frame_err === 1'b1) n_err = n_err + 1;
    if (o_valid === 1'b1 && o_frame_err === 1'b1) n_both = n_both + 1;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One bck period = 4 clk: 2 low, 2 high; pins change on the falling edge. Called at a clk negedge.
  task automatic drive_bit(input logic lr, input logic d, input logic mark);
    i_bck   = 1'b0;
    i_lrck  = lr;
    i_adata = d;
    repeat (2) @(negedge clk);
    i_bck = 1'b1;
    if (mark) rise_cyc = cyc;
    repeat (2) @(negedge clk);
  endtask

  // Slot bits first..last-1 of a 32-bit slot; bit 0 is the delay bit, bits 1..DW carry the word MSB first.
  task automatic send_slot(input logic lr, input logic [DW-1:0] w, input int first, input int last);
    logic d;
    for (int i = first; i < last; i++) begin
      d = (i >= 1 && i <= DW) ? w[DW-i] : 1'b0;
      drive_bit(lr, d, lr && (i == DW));
    end
  endtask

  task automatic send_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    send_slot(1'b0, l, 0, 32);
    send_slot(1'b1, r, 0, 32);
  endtask

  function automatic logic [DW-1:0] sine_smp(input int n);
    real v;
    v = 8000000.0 * $sin(2.0 * 3.14159265358979 * 500.0 * real'(n) / 48000.0);
    return DW'($rtoi(v));
  endfunction

  initial begin
    int base_v;
    int base_e;
    logic [DW-1:0] sl;
    logic [DW-1:0] sr;

    rst_n   = 1'b0;
    i_bck   = 1'b0;
    i_lrck  = 1'b0;
    i_adata = 1'b0;
    repeat (3) @(negedge clk);

    // Pins toggle while held in reset, then reset releases halfway through a right slot.
    send_pair(24'h111111, 24'h222222);
    send_slot(1'b1, 24'h333333, 0, 16);
    chk_eq("rst_left", 32'(o_left), 32'h0);
    chk_eq("rst_right", 32'(o_right), 32'h0);
    chk_eq("rst_valid", 32'(o_valid), 32'h0);
    chk_eq("rst_ferr", 32'(o_frame_err), 32'h0);
    chk_eq("rst_sticky", 32'(o_err_sticky), 32'h0);
    chk_eq("rst_pulses", 32'(n_valid + n_err), 32'h0);
    rst_n = 1'b1;
    send_slot(1'b1, 24'h333333, 16, 32);
    chk_eq("startup_no_valid", 32'(n_valid), 32'h0);

    // Nominal frame.
    send_pair(24'h123456, 24'hABCDEF);
    chk_eq("nom_count", 32'(n_valid), 32'd1);
    chk_eq("nom_left", 32'(last_l), 32'h123456);
    chk_eq("nom_right", 32'(last_r), 32'hABCDEF);
    chk_eq("nom_latency", 32'(vld_cyc - rise_cyc), 32'd5);
    chk_eq("nom_no_err", 32'(n_err), 32'd0);

    // Short left word: 10 data bits, then a right word that must be dropped.
    send_slot(1'b0, 24'hFFFFFF, 0, 11);
    send_slot(1'b1, 24'h654321, 0, 32);
    chk_eq("short_err", 32'(n_err), 32'd1);
    chk_eq("short_sticky", 32'(o_err_sticky), 32'd1);
    chk_eq("short_no_valid", 32'(n_valid), 32'd1);
    chk_eq("hold_left", 32'(o_left), 32'h123456);
    chk_eq("hold_right", 32'(o_right), 32'hABCDEF);
    send_pair(24'h000001, 24'hFFFFFF);
    chk_eq("recov_count", 32'(n_valid), 32'd2);
    chk_eq("recov_left", 32'(last_l), 32'h000001);
    chk_eq("recov_right", 32'(last_r), 32'hFFFFFF);
    chk_eq("recov_err", 32'(n_err), 32'd1);

    // Asynchronous reset during bit 12 of a left word.
    send_slot(1'b0, 24'h5A5A5A, 0, 13);
    rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_left", 32'(o_left), 32'h0);
    chk_eq("mid_rst_right", 32'(o_right), 32'h0);
    chk_eq("mid_rst_sticky", 32'(o_err_sticky), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base_v = n_valid;
    base_e = n_err;
    send_slot(1'b0, 24'h5A5A5A, 13, 32);
    send_slot(1'b1, 24'h777777, 0, 32);
    chk_eq("mid_rst_lone_right", 32'(n_valid - base_v), 32'd0);
    send_pair(24'h0F0F0F, 24'hF0F0F0);
    chk_eq("mid_rst_count", 32'(n_valid - base_v), 32'd1);
    chk_eq("mid_rst_pl", 32'(last_l), 32'h0F0F0F);
    chk_eq("mid_rst_pr", 32'(last_r), 32'hF0F0F0);
    chk_eq("mid_rst_err", 32'(n_err - base_e), 32'd0);

    // 200 back-to-back sine frames.
    base_v = n_valid;
    base_e = n_err;
    for (int f = 0; f < 200; f++) begin
      sl = sine_smp(f);
      sr = sine_smp(f + 24);
      send_pair(sl, sr);
      chk_eq("sine_left", 32'(last_l), 32'(sl));
      chk_eq("sine_right", 32'(last_r), 32'(sr));
      if (f == 0) chk_eq("sine_latency", 32'(vld_cyc - rise_cyc), 32'd5);
    end
    chk_eq("sine_count", 32'(n_valid - base_v), 32'd200);
    chk_eq("sine_errs", 32'(n_err - base_e), 32'd0);
    chk_eq("sine_sticky", 32'(o_err_sticky), 32'd0);
    chk_eq("valid_err_overlap", 32'(n_both), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
